// File: rtl/intersection_ctrl_pkg.sv
// Shared types for the intersection controller: state encoding,
// default dwell times and the {red, yellow, green} lamp tuple.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        NS_CLEAR  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        EW_CLEAR  = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    localparam int GREEN_DEF  = 20;
    localparam int YELLOW_DEF = 5;
    localparam int ALLRED_DEF = 2;
    localparam int WALK_DEF   = 10;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamp_t;

    localparam lamp_t LAMP_RED = 3'b100;
    localparam lamp_t LAMP_YEL = 3'b010;
    localparam lamp_t LAMP_GRN = 3'b001;

    typedef struct packed {
        lamp_t ns;
        lamp_t ew;
        logic  walk;
    } heads_t;

    // Both roads default to red; only the served road lights otherwise.
    function automatic heads_t decode(state_t s);
        heads_t h;
        h.ns   = LAMP_RED;
        h.ew   = LAMP_RED;
        h.walk = 1'b0;
        case (s)
            NS_GREEN:  h.ns = LAMP_GRN;
            NS_YELLOW: h.ns = LAMP_YEL;
            EW_GREEN:  h.ew = LAMP_GRN;
            EW_YELLOW: h.ew = LAMP_YEL;
            PED_WALK:  h.walk = 1'b1;
            default: ;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/intersection_ctrl_if.sv
// Control and lamp bundle between the intersection controller
// and its environment (request input, lamp heads, debug taps).
interface intersection_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             ped_req;
    logic             ped_ack;
    logic             ns_red;
    logic             ns_yellow;
    logic             ns_green;
    logic             ew_red;
    logic             ew_yellow;
    logic             ew_green;
    logic             walk;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] count_o;

    modport master (
        output enable, ped_req,
        input  ped_ack, ns_red, ns_yellow, ns_green,
        input  ew_red, ew_yellow, ew_green, walk,
        input  state_o, count_o
    );

    modport slave (
        input  enable, ped_req,
        output ped_ack, ns_red, ns_yellow, ns_green,
        output ew_red, ew_yellow, ew_green, walk,
        output state_o, count_o
    );
endinterface

// File: rtl/intersection_ctrl_phase_timer.sv
// Phase dwell counter: counts 0..tc-1 while enabled, done on the
// last enabled cycle, cleared by the FSM on every transition.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] tc,
    output logic [CNT_W-1:0] count,
    output logic             done
);
    assign done = enable && (count == tc - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + CNT_W'(1);
    end
endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection sequencer with all-red clearance and a
// latched pedestrian walk phase; lamps are registered from state.
module intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = GREEN_DEF,
    parameter int YELLOW_TICKS = YELLOW_DEF,
    parameter int ALLRED_TICKS = ALLRED_DEF,
    parameter int WALK_TICKS   = WALK_DEF,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    intersection_ctrl_if.slave bus
);
    state_t           state;
    state_t           nxt;
    heads_t           heads;
    logic [CNT_W-1:0] tc;
    logic [CNT_W-1:0] count;
    logic             done;
    logic             walk_go;
    logic             ped_pending;
    logic             resume_ew;

    always_comb begin
        tc = CNT_W'(WALK_TICKS);
        unique case (state)
            NS_GREEN, EW_GREEN:   tc = CNT_W'(GREEN_TICKS);
            NS_YELLOW, EW_YELLOW: tc = CNT_W'(YELLOW_TICKS);
            NS_CLEAR, EW_CLEAR:   tc = CNT_W'(ALLRED_TICKS);
            default:              tc = CNT_W'(WALK_TICKS);
        endcase
    end

    always_comb begin
        nxt = state;
        unique case (state)
            NS_GREEN:  nxt = NS_YELLOW;
            NS_YELLOW: nxt = NS_CLEAR;
            NS_CLEAR:  nxt = ped_pending ? PED_WALK : EW_GREEN;
            EW_GREEN:  nxt = EW_YELLOW;
            EW_YELLOW: nxt = EW_CLEAR;
            EW_CLEAR:  nxt = ped_pending ? PED_WALK : NS_GREEN;
            default:   nxt = resume_ew ? EW_GREEN : NS_GREEN;
        endcase
    end

    assign walk_go = done && (nxt == PED_WALK);

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (bus.enable),
        .clear  (done),
        .tc     (tc),
        .count  (count),
        .done   (done)
    );

    // Entering the walk wins over a same-cycle request: it is served.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= NS_GREEN;
            heads       <= decode(NS_GREEN);
            ped_pending <= 1'b0;
            resume_ew   <= 1'b0;
            bus.ped_ack <= 1'b0;
        end else begin
            bus.ped_ack <= walk_go;
            if (walk_go)
                ped_pending <= 1'b0;
            else if (bus.ped_req && state != PED_WALK)
                ped_pending <= 1'b1;
            if (walk_go)
                resume_ew <= (state == NS_CLEAR);
            if (done) begin
                state <= nxt;
                heads <= decode(nxt);
            end
        end
    end

    assign bus.ns_red    = heads.ns.red;
    assign bus.ns_yellow = heads.ns.yellow;
    assign bus.ns_green  = heads.ns.green;
    assign bus.ew_red    = heads.ew.red;
    assign bus.ew_yellow = heads.ew.yellow;
    assign bus.ew_green  = heads.ew.green;
    assign bus.walk      = heads.walk;
    assign bus.state_o   = state;
    assign bus.count_o   = count;
endmodule
